// File: rtl/gmii_rx_framer_if.sv
// Signal bundle between the GMII receive path, the framer and the payload consumer.
// master drives the GMII byte stream and observes the framer; slave is the framer side.
interface gmii_rx_framer_if;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        frame_end;
  logic        frame_ok;
  logic        crc_err;
  logic        len_err;
  logic [15:0] frame_len;

  modport master (
    output gmii_rx_dv, gmii_rxd,
    input  out_valid, out_data, out_sof, frame_end, frame_ok, crc_err, len_err, frame_len
  );

  modport slave (
    input  gmii_rx_dv, gmii_rxd,
    output out_valid, out_data, out_sof, frame_end, frame_ok, crc_err, len_err, frame_len
  );
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD/FCS, checks length and (optionally) FCS.
// Define GMII_RX_CRC_CHECK_EN to build the CRC-32 checker; otherwise crc_err is tied low.
module gmii_rx_framer #(
  parameter int unsigned MIN_PREAMBLE = 2,
  parameter int unsigned MAX_FRAME    = 1518,
  parameter int unsigned MIN_FRAME    = 64
) (
  input  logic            gmii_rx_clk,
  input  logic            rst,
  gmii_rx_framer_if.slave gmii
);

  localparam logic [3:0]  MinPre   = 4'(MIN_PREAMBLE);
  localparam logic [16:0] MaxFrame = 17'(MAX_FRAME);
  localparam logic [16:0] MinFrame = 17'(MIN_FRAME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [31:0] hold_q, hold_d;
  logic [16:0] total_q, total_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sof_q, out_sof_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        frame_end_q, frame_end_d;
  logic        frame_ok_q, frame_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic        len_bad;
  logic        crc_bad;
  logic [16:0] len_full;

  logic        sfd_ok;
  logic        data_byte;

  assign sfd_ok    = (state_q == S_PREAMBLE) && gmii.gmii_rx_dv &&
                     (gmii.gmii_rxd == 8'hD5) && (pre_cnt_q >= MinPre);
  assign data_byte = (state_q == S_DATA) && gmii.gmii_rx_dv;

`ifdef GMII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h000000, b};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (sfd_ok) begin
      crc_d = '1;
    end else if (data_byte) begin
      crc_d = crc32_byte(crc_q, gmii.gmii_rxd);
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      crc_q <= '1;
    end else begin
      crc_q <= crc_d;
    end
  end

  // Running the CRC over the FCS too leaves the fixed residue on a good frame.
  assign crc_bad = (crc_q != 32'hDEBB20E3);
`else
  assign crc_bad = 1'b0;
`endif

  assign len_bad  = (total_q < MinFrame) || (total_q > MaxFrame);
  assign len_full = total_q - 17'd4;

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    hold_d      = hold_q;
    total_d     = total_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_data_d  = out_data_q;
    frame_end_d = 1'b0;
    frame_ok_d  = frame_ok_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    frame_len_d = frame_len_q;

    case (state_q)
      S_IDLE: begin
        if (gmii.gmii_rx_dv) begin
          if (gmii.gmii_rxd == 8'h55) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!gmii.gmii_rx_dv) begin
          state_d = S_IDLE;
        end else if (gmii.gmii_rxd == 8'h55) begin
          pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
        end else if (sfd_ok) begin
          state_d = S_DATA;
          hold_d  = '0;
          total_d = '0;
        end else begin
          state_d = S_DROP;
        end
      end

      S_DATA: begin
        if (gmii.gmii_rx_dv) begin
          hold_d  = {hold_q[23:0], gmii.gmii_rxd};
          total_d = (total_q == '1) ? total_q : total_q + 17'd1;
          // total_q >= 4 means the holdback is full; the oldest byte has index total_q-4.
          if ((total_q >= 17'd4) && (total_q < MaxFrame)) begin
            out_valid_d = 1'b1;
            out_sof_d   = (total_q == 17'd4);
            out_data_d  = hold_q[31:24];
          end
        end else begin
          state_d     = S_IDLE;
          frame_end_d = 1'b1;
          len_err_d   = len_bad;
          crc_err_d   = crc_bad;
          frame_ok_d  = !len_bad && !crc_bad;
          if (total_q < 17'd4) begin
            frame_len_d = '0;
          end else if (len_full[16]) begin
            frame_len_d = '1;
          end else begin
            frame_len_d = len_full[15:0];
          end
        end
      end

      S_DROP: begin
        if (!gmii.gmii_rx_dv) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      hold_q      <= '0;
      total_q     <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
      frame_end_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      hold_q      <= hold_d;
      total_q     <= total_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_data_q  <= out_data_d;
      frame_end_q <= frame_end_d;
      frame_ok_q  <= frame_ok_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign gmii.out_valid = out_valid_q;
  assign gmii.out_sof   = out_sof_q;
  assign gmii.out_data  = out_data_q;
  assign gmii.frame_end = frame_end_q;
  assign gmii.frame_ok  = frame_ok_q;
  assign gmii.crc_err   = crc_err_q;
  assign gmii.len_err   = len_err_q;
  assign gmii.frame_len = frame_len_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomized self-checking bench for gmii_rx_framer against a frame-level reference model.
module tb_gmii_rx_framer;

  localparam int MIN_PRE = 2;
  localparam int MAX_FR  = 1518;
  localparam int MIN_FR  = 64;

  typedef struct packed {
    logic       sof;
    logic [7:0] d;
  } exp_byte_t;

  typedef struct packed {
    logic        ok;
    logic        crc;
    logic        len;
    logic [15:0] flen;
  } exp_stat_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   t_first;
  int   last_sof_cyc;
  int   body_start;

  logic [7:0] burst[$];
  exp_byte_t  exp_q[$];
  exp_stat_t  stat_q[$];
  exp_byte_t  mon_e;
  exp_stat_t  mon_s;

  gmii_rx_framer_if bus ();

  gmii_rx_framer #(
    .MIN_PREAMBLE(MIN_PRE),
    .MAX_FRAME   (MAX_FR),
    .MIN_FRAME   (MIN_FR)
  ) dut (
    .gmii_rx_clk(clk),
    .rst        (rst),
    .gmii       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Builds preamble + SFD + payload + FCS into burst; pat 0 = incrementing, 1 = random.
  task automatic build_frame(input int npre, input int nbody, input int pat, input logic corrupt);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    burst.delete();
    for (int i = 0; i < npre; i++) burst.push_back(8'h55);
    burst.push_back(8'hD5);
    body_start = npre + 1;
    c = '1;
    for (int i = 0; i < nbody; i++) begin
      b = (pat == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      burst.push_back(b);
      c = crc_step(c, b);
    end
    fcs = ~c;
    burst.push_back(fcs[7:0]);
    burst.push_back(fcs[15:8]);
    burst.push_back(fcs[23:16]);
    burst.push_back(corrupt ? (fcs[31:24] ^ 8'h01) : fcs[31:24]);
  endtask

  // Frame-level reference: parses a whole dv burst and queues the expected outputs.
  task automatic model_burst();
    int        i;
    int        n55;
    int        total;
    int        npay;
    logic [31:0] c;
    exp_byte_t e;
    exp_stat_t s;
    i = 0;
    n55 = 0;
    while (i < burst.size() && burst[i] == 8'h55) begin
      n55++;
      i++;
    end
    if (n55 == 0 || i >= burst.size() || burst[i] != 8'hD5 || n55 < MIN_PRE) return;
    total = burst.size() - i - 1;
    c = '1;
    for (int k = i + 1; k < burst.size(); k++) c = crc_step(c, burst[k]);
    npay = (total < 4) ? 0 : ((total - 4 < MAX_FR - 4) ? total - 4 : MAX_FR - 4);
    for (int k = 0; k < npay; k++) begin
      e.sof = (k == 0);
      e.d   = burst[i + 1 + k];
      exp_q.push_back(e);
    end
`ifdef GMII_RX_CRC_CHECK_EN
    s.crc = (c != 32'hDEBB20E3);
`else
    s.crc = 1'b0;
`endif
    s.len  = (total < MIN_FR) || (total > MAX_FR);
    s.ok   = !s.crc && !s.len;
    s.flen = (total < 4) ? 16'd0 : ((total - 4 > 65535) ? 16'hFFFF : 16'(total - 4));
    stat_q.push_back(s);
  endtask

  task automatic check_outputs_zero(input string where);
    chk({where, "_out_valid"}, bus.out_valid, 0);
    chk({where, "_out_sof"},   bus.out_sof,   0);
    chk({where, "_out_data"},  bus.out_data,  0);
    chk({where, "_frame_end"}, bus.frame_end, 0);
    chk({where, "_frame_ok"},  bus.frame_ok,  0);
    chk({where, "_crc_err"},   bus.crc_err,   0);
    chk({where, "_len_err"},   bus.len_err,   0);
    chk({where, "_frame_len"}, bus.frame_len, 0);
  endtask

  task automatic send_burst(input int gap, input int rst_at);
    for (int i = 0; i < burst.size(); i++) begin
      bus.gmii_rx_dv = 1'b1;
      bus.gmii_rxd   = burst[i];
      rst            = (i == rst_at);
      if (i == body_start) t_first = cyc;
      @(posedge clk);
      #1;
      if (i == rst_at) begin
        rst = 1'b0;
        check_outputs_zero("after_rst");
      end
    end
    rst = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rxd   = 8'h00;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int npre, input int nbody, input int pat, input logic corrupt,
                           input int gap);
    build_frame(npre, nbody, pat, corrupt);
    model_burst();
    send_burst(gap, -1);
  endtask

  always @(negedge clk) begin
    if (bus.out_sof && !bus.out_valid) chk("sof_without_valid", bus.out_sof, 0);
    if (bus.out_valid) begin
      chk("byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("out_data", bus.out_data, mon_e.d);
        chk("out_sof", bus.out_sof, mon_e.sof);
      end
      if (bus.out_sof) last_sof_cyc = cyc;
    end
    if (bus.frame_end) begin
      chk("frame_end_expected", 32'(stat_q.size() != 0), 1);
      if (stat_q.size() != 0) begin
        mon_s = stat_q.pop_front();
        chk("frame_ok",  bus.frame_ok,  mon_s.ok);
        chk("crc_err",   bus.crc_err,   mon_s.crc);
        chk("len_err",   bus.len_err,   mon_s.len);
        chk("frame_len", bus.frame_len, mon_s.flen);
      end
    end
  end

  initial begin
    exp_byte_t e;
    int        kind;
    n_checks       = 0;
    n_fail         = 0;
    cyc            = 0;
    last_sof_cyc   = -100;
    t_first        = 0;
    body_start     = 0;
    rst            = 1'b1;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rxd   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Nominal 60-byte frame and first-byte latency.
    run_frame(7, 60, 0, 1'b0, 3);
    chk("sof_latency", 32'(last_sof_cyc - t_first), 5);

    // Corrupted last FCS byte.
    run_frame(7, 60, 0, 1'b1, 3);

    // Runt with good FCS.
    run_frame(7, 20, 0, 1'b0, 3);

    // Broken preamble, then a good frame.
    burst.delete();
    burst.push_back(8'h55);
    burst.push_back(8'h55);
    burst.push_back(8'h54);
    burst.push_back(8'h55);
    burst.push_back(8'hD5);
    for (int i = 0; i < 60; i++) burst.push_back(8'(i));
    body_start = 5;
    model_burst();
    send_burst(2, -1);
    run_frame(7, 60, 0, 1'b0, 3);

    // Back-to-back frames with a single idle cycle.
    run_frame(7, 60, 1, 1'b0, 1);
    run_frame(7, 60, 1, 1'b0, 3);

    // Reset while payload byte 30 is on the wire: bytes 0..25 already left.
    build_frame(7, 60, 0, 1'b0);
    for (int k = 0; k < 26; k++) begin
      e.sof = (k == 0);
      e.d   = 8'(k);
      exp_q.push_back(e);
    end
    send_burst(3, 7 + 1 + 30);
    run_frame(7, 60, 0, 1'b0, 3);

    // Length and preamble boundaries.
    run_frame(2, 59, 1, 1'b0, 2);
    run_frame(2, 60, 1, 1'b0, 2);
    run_frame(1, 60, 1, 1'b0, 2);
    run_frame(15, 60, 1, 1'b0, 1);
    run_frame(7, MAX_FR - 4, 1, 1'b0, 2);
    run_frame(7, MAX_FR - 3, 1, 1'b0, 2);
    run_frame(7, MAX_FR + 8, 1, 1'b1, 2);
    burst.delete();
    burst.push_back(8'h55);
    burst.push_back(8'h55);
    burst.push_back(8'hD5);
    burst.push_back(8'hA1);
    burst.push_back(8'hB2);
    burst.push_back(8'hC3);
    body_start = 3;
    model_burst();
    send_burst(2, -1);

    // Randomized traffic including garbage bursts.
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        burst.delete();
        for (int i = 0; i < $urandom_range(3, 20); i++) burst.push_back(8'($urandom_range(0, 255)));
        body_start = -1;
        model_burst();
        send_burst($urandom_range(1, 4), -1);
      end else begin
        run_frame($urandom_range(1, 9), $urandom_range(0, 130), 1,
                  ($urandom_range(0, 3) == 0), $urandom_range(1, 4));
      end
    end

    repeat (10) @(posedge clk);
    #1;
    chk("payload_left", exp_q.size(), 0);
    chk("status_left", stat_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gmii_rx_framer.md
# gmii_rx_framer

GMII receive framer sitting directly downstream of the RGMII-to-GMII receive converter. It consumes the 8-bit GMII byte stream (data-valid plus data) in the receive clock domain and delineates Ethernet frames. It strips the preamble, the SFD and the 4-byte FCS, and checks the FCS and the frame length. Payload bytes go to the MAC/UDP parser with a start-of-frame marker, followed by a one-cycle per-frame status pulse.

## Interface
- MIN_PREAMBLE, 2: minimum number of 0x55 bytes required before the SFD.
- MAX_FRAME, 1518: maximum legal frame length in bytes, FCS included.
- MIN_FRAME, 64: minimum legal frame length in bytes, FCS included.

- gmii_rx_clk  input  1  receive byte clock, 125 MHz; the only clock.
- rst  input  1  synchronous, active-high reset.
- gmii_rx_dv  input  1  GMII data valid.
- gmii_rxd  input  8  GMII receive byte.
- out_valid  output  1  out_data holds a payload byte this cycle.
- out_data  output  8  payload byte (destination MAC onward, FCS excluded).
- out_sof  output  1  marks the first payload byte of a frame; only asserted with out_valid.
- frame_end  output  1  one-cycle pulse carrying the end-of-frame status.
- frame_ok  output  1  valid with frame_end: no crc_err and no len_err.
- crc_err  output  1  valid with frame_end: FCS residue mismatch.
- len_err  output  1  valid with frame_end: total length below MIN_FRAME or above MAX_FRAME.
- frame_len  output  16  valid with frame_end: payload byte count (FCS excluded), saturating at 0xFFFF.

## Operation
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - gmii_rx_dv=1 with rxd=0x55 -> PREAMBLE, preamble count=1.
  - Any other byte with dv=1 -> DROP.
- PREAMBLE:
  - 0x55 -> count++, saturating at 15.
  - 0xD5 with count>=MIN_PREAMBLE -> DATA; CRC is initialised to 0xFFFFFFFF and the 4-byte holdback register is cleared.
  - 0xD5 with count<MIN_PREAMBLE, or any other byte -> DROP.
  - dv=0 -> IDLE. No frame_end is emitted.
- DATA:
  - Each byte shifts into a 4-byte holdback register. Once 4 bytes are held, each new byte pushes the oldest byte out as a payload byte.
  - The first pushed byte carries out_sof.
  - The CRC covers every byte after the SFD, FCS included.
  - dv=0 -> IDLE and frame_end is emitted.
- DROP: wait for dv=0, then go to IDLE. There are no outputs in this state.
- CRC: reflected CRC-32 with polynomial 0xEDB88320, processing 1 byte per cycle. After the last FCS byte the register must equal 0xDEBB20E3, otherwise crc_err=1.
- Total length = bytes after the SFD.
  - If total < MIN_FRAME or total > MAX_FRAME -> len_err=1.
  - frame_len = total-4, or 0 if total<4. If total<4, then len_err=1 and no payload is output.
- Oversize frames: payload bytes beyond MAX_FRAME-4 are not output (out_valid suppressed). Counting continues until dv=0.
- frame_ok = !crc_err && !len_err.

## Timing
- Reset values: state=IDLE; all outputs 0, including out_data=0x00 and frame_len=0.
  - Reset is synchronous and wins over all other activity.
  - Reset mid-frame aborts the frame with no frame_end; reception resumes at the next IDLE->PREAMBLE transition.
- Latency: a byte presented on gmii_rxd in cycle c (with dv=1) appears on out_data in cycle c+5. Throughput is 1 byte/cycle with no gaps inside a frame.
- If the first cycle with dv=0 after DATA is cycle d:
  - The last payload byte is valid in cycle d.
  - frame_end plus status are valid in cycle d+1 only.
  - The status outputs hold their values until the next frame_end. frame_end itself is 1 cycle wide.
- Back-to-back frames with a 1-cycle dv=0 gap must be received correctly. The frame_end of frame N may coincide with the preamble bytes of frame N+1.
- There is no backpressure; the downstream block must accept a byte in every cycle where out_valid=1.

## Configuration
- GMII_RX_CRC_CHECK_EN
  - Defined: the CRC-32 engine is built and crc_err behaves as specified above.
  - Undefined: no CRC logic is built, crc_err is tied to 0, and frame_ok = !len_err. The FCS is still stripped, and latency is unchanged.

## Test plan
- 7x0x55, 0xD5, payload bytes 0x00..0x3B (60 bytes), correct FCS:
  - 60 out_valid cycles, with out_sof on byte 0x00.
  - frame_end with frame_ok=1, crc_err=0, len_err=0, frame_len=60.
  - First payload byte appears 5 cycles after it is presented on gmii_rxd.
- Same frame with the last FCS byte XOR 0x01:
  - Identical payload output.
  - frame_end with crc_err=1, frame_ok=0 (macro defined); crc_err=0, frame_ok=1 (macro undefined).
- Runt frame of 20 payload bytes plus a correct FCS: 20 payload bytes output; len_err=1, frame_ok=0, frame_len=20.
- Preamble 0x55,0x55,0x54,0x55,0xD5 followed by 60 bytes: no out_valid and no frame_end. A following good frame is received normally.
- Two good 60-byte frames separated by one dv=0 cycle: two frame_end pulses, each with frame_ok=1, and 120 payload bytes output.
- rst asserted for 1 cycle at payload byte 30: all outputs are 0 on the next cycle and no frame_end occurs. The next good frame is received correctly with frame_len=60.
